// File: rtl/dbg_state_loader.sv
// Debug write port into the core's architectural state: parses a byte-stream
// command protocol and commits 32-bit words to the register file or data memory.
module dbg_state_loader #(
  parameter int DM_AW         = 5,
  parameter int TIMEOUT       = 255,
  parameter bit HALT_ON_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             core_halt,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             dm_we,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_wdata,
  output logic             err,
  output logic [15:0]      wr_count
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [7:0] CMD_HALT    = 8'hA0;
  localparam logic [7:0] CMD_WR_REG  = 8'hA1;
  localparam logic [7:0] CMD_WR_MEM  = 8'hA2;
  localparam logic [7:0] CMD_RELEASE = 8'hA5;

  typedef enum logic [1:0] {
    S_CMD,
    S_ADDR,
    S_DATA,
    S_COMMIT
  } state_t;

  state_t          state;
  logic [1:0]      idx;
  logic [TW-1:0]   tcnt;
  logic            is_mem;
  logic            bad;
  logic [7:0]      addr_q;
  logic [23:0]     data_q;

  logic            accept;
  logic            in_frame;
  logic            timed_out;
  logic            reg_addr_bad;
  logic            mem_addr_bad;
  logic [31:0]     word;

  always_comb begin
    accept       = in_valid && in_ready;
    in_frame     = (state == S_ADDR) || (state == S_DATA);
    timed_out    = in_frame && !accept && (tcnt == TW'(TIMEOUT - 1));
    reg_addr_bad = (in_data[7:5] != 3'd0) || (in_data == 8'd0);
    mem_addr_bad = {24'd0, in_data} >= (32'd1 << DM_AW);
    word         = {in_data, data_q};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_CMD;
      in_ready  <= 1'b1;
      core_halt <= HALT_ON_RESET;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_wdata  <= '0;
      err       <= 1'b0;
      wr_count  <= '0;
      idx       <= '0;
      tcnt      <= '0;
      is_mem    <= 1'b0;
      bad       <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      rf_we <= 1'b0;
      dm_we <= 1'b0;
      err   <= 1'b0;

      // An accepted byte always clears the idle counter, so a byte arriving on
      // the cycle the counter would expire keeps the frame alive.
      if (in_frame) begin
        if (accept) begin
          tcnt <= '0;
        end else if (timed_out) begin
          tcnt  <= '0;
          err   <= 1'b1;
          state <= S_CMD;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end

      case (state)
        S_CMD: begin
          if (accept) begin
            case (in_data)
              CMD_WR_REG, CMD_WR_MEM: begin
                is_mem <= (in_data == CMD_WR_MEM);
                bad    <= !core_halt;
                state  <= S_ADDR;
              end
              CMD_HALT:    core_halt <= 1'b1;
              CMD_RELEASE: core_halt <= 1'b0;
              default:     err       <= 1'b1;
            endcase
          end
        end

        S_ADDR: begin
          if (accept) begin
            addr_q <= in_data;
            bad    <= bad || (is_mem ? mem_addr_bad : reg_addr_bad);
            idx    <= '0;
            state  <= S_DATA;
          end
        end

        S_DATA: begin
          if (accept) begin
            data_q <= {in_data, data_q[23:8]};
            idx    <= idx + 2'd1;
            if (idx == 2'd3) begin
              state    <= S_COMMIT;
              in_ready <= 1'b0;
              if (bad) begin
                err <= 1'b1;
              end else begin
                if (is_mem) begin
                  dm_we    <= 1'b1;
                  dm_addr  <= DM_AW'(addr_q);
                  dm_wdata <= word;
                end else begin
                  rf_we    <= 1'b1;
                  rf_waddr <= addr_q[4:0];
                  rf_wdata <= word;
                end
                if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
              end
            end
          end
        end

        S_COMMIT: begin
          state    <= S_CMD;
          in_ready <= 1'b1;
        end

        default: begin
          state    <= S_CMD;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
